// File: rtl/node_traffic_gen_pkg.sv
// Shared types and constants for the per-node traffic generator.
// The random-destination mode is selected with NODE_TRAFFIC_RANDOM_EN.
package node_traffic_gen_pkg;

   localparam int NODES  = 16;
   localparam int NODE_W = $clog2(NODES);

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Feedback taps x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef struct packed {
      logic [NODE_W-1:0] dest;
      logic [NODE_W-1:0] source;
      logic [7:0]        seq;
   } packet_t;

   localparam int PKT_W = $bits(packet_t);

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/node_traffic_gen_fifo.sv
// First-word fall-through injection FIFO; pointers carry one extra wrap bit
// so full and empty come straight from the pointer MSBs.
module node_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_q, wr_d;
   logic [AW:0]  rd_q, rd_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign head_o  = mem_q[rd_q[AW-1:0]];

   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/node_traffic_gen.sv
// Periodic synthetic packet source feeding one node's injection port.
// Define NODE_TRAFFIC_RANDOM_EN for LFSR destinations; default is the next node.
module node_traffic_gen
   import node_traffic_gen_pkg::*;
#(
   parameter int NODE_ID    = 0,
   parameter int PERIOD     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_gen_en,
   input  logic        i_en,
   output packet_t     o_data,
   output logic        o_data_val,
   output logic [15:0] o_sent_count,
   output logic [15:0] o_drop_count
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0]     C_LAST = CW'(PERIOD - 1);
   localparam logic [NODE_W-1:0] MY_ID  = NODE_W'(NODE_ID);

   logic [CW-1:0] c_q, c_d;
   logic [7:0]    seq_q, seq_d;
   logic [15:0]   sent_q, sent_d;
   logic [15:0]   drop_q, drop_d;
   logic          tick;
   logic          pop;
   logic          push_ok;
   logic          full;
   logic          empty;
   logic [NODE_W-1:0] dest;
   logic [PKT_W-1:0]  head;
   packet_t           pkt;

   assign tick    = i_gen_en && (c_q == C_LAST);
   assign pop     = !empty && i_en;
   assign push_ok = tick && (!full || pop);

`ifdef NODE_TRAFFIC_RANDOM_EN
   logic [15:0]       lfsr_q, lfsr_d;
   logic [NODE_W-1:0] raw_dest;

   // Destination comes from the state before this tick's shift; never self.
   assign raw_dest = lfsr_q[NODE_W-1:0];
   assign dest     = (raw_dest == MY_ID) ? (raw_dest ^ NODE_W'(1)) : raw_dest;
   assign lfsr_d   = tick ? lfsr_next(lfsr_q) : lfsr_q;

   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= LFSR_SEED ^ 16'(NODE_ID);
      else       lfsr_q <= lfsr_d;
   end
`else
   assign dest = NODE_W'((NODE_ID + 1) % NODES);
`endif

   always_comb begin
      pkt.dest   = dest;
      pkt.source = MY_ID;
      pkt.seq    = seq_q;
   end

   always_comb begin
      c_d    = !i_gen_en ? '0 : (tick ? '0 : c_q + 1'b1);
      seq_d  = push_ok ? seq_q + 8'd1 : seq_q;
      sent_d = (pop && sent_q != 16'hFFFF) ? sent_q + 16'd1 : sent_q;
      drop_d = (tick && !push_ok && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         c_q    <= '0;
         seq_q  <= '0;
         sent_q <= '0;
         drop_q <= '0;
      end else begin
         c_q    <= c_d;
         seq_q  <= seq_d;
         sent_q <= sent_d;
         drop_q <= drop_d;
      end
   end

   node_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (PKT_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_ok),
      .data_i  (pkt),
      .pop_i   (pop),
      .full_o  (full),
      .empty_o (empty),
      .head_o  (head)
   );

   assign o_data       = packet_t'(head);
   assign o_data_val   = !empty;
   assign o_sent_count = sent_q;
   assign o_drop_count = drop_q;

endmodule

// File: tb/tb_node_traffic_gen.sv
// Bench for node_traffic_gen: directed phases plus a cycle model whose expected
// packets sit in a queue and are compared as the DUT presents them.
module tb_node_traffic_gen;
   import node_traffic_gen_pkg::*;

`ifdef NODE_TRAFFIC_RANDOM_EN
   localparam int NID = 5;
`else
   localparam int NID = 3;
`endif
   localparam int PERIOD = 4;
   localparam int DEPTH  = 4;
   localparam int W      = PKT_W;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_gen_en = 1'b1;
   logic        i_en = 1'b1;
   packet_t     o_data;
   logic        o_data_val;
   logic [15:0] o_sent_count;
   logic [15:0] o_drop_count;

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] exp_q[$];
   packet_t      log_q[$];
   int           m_c = 0;
   logic [7:0]   m_seq = 8'd0;
   logic [15:0]  m_sent = 16'd0;
   logic [15:0]  m_drop = 16'd0;
   logic [15:0]  m_lfsr = 16'hACE1 ^ 16'(NID);

   node_traffic_gen #(
      .NODE_ID    (NID),
      .PERIOD     (PERIOD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_gen_en     (i_gen_en),
      .i_en         (i_en),
      .o_data       (o_data),
      .o_data_val   (o_data_val),
      .o_sent_count (o_sent_count),
      .o_drop_count (o_drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Spec-level model: one update per rising edge from the inputs seen there.
   task automatic model_loop();
      logic            tick;
      logic            pop;
      logic [3:0]      d;
      logic            fb;
      packet_t         p;
      forever begin
         @(posedge clk);
         if (reset) begin
            m_c = 0; m_seq = 8'd0; m_sent = 16'd0; m_drop = 16'd0;
            m_lfsr = 16'hACE1 ^ 16'(NID);
            exp_q.delete();
         end else begin
            tick = i_gen_en && (m_c == PERIOD - 1);
            pop  = (exp_q.size() != 0) && i_en;
            if (pop) begin
               void'(exp_q.pop_front());
               if (m_sent != 16'hFFFF) m_sent = m_sent + 16'd1;
            end
            if (tick) begin
`ifdef NODE_TRAFFIC_RANDOM_EN
               d = m_lfsr[3:0];
               if (d == 4'(NID)) d = d ^ 4'd1;
               fb = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
               m_lfsr = {m_lfsr[14:0], fb};
`else
               d = 4'((NID + 1) % 16);
               fb = 1'b0;
`endif
               if (exp_q.size() < DEPTH) begin
                  p.dest = d; p.source = 4'(NID); p.seq = m_seq;
                  exp_q.push_back(p);
                  m_seq = m_seq + 8'd1;
               end else if (m_drop != 16'hFFFF) begin
                  m_drop = m_drop + 16'd1;
               end
            end
            m_c = !i_gen_en ? 0 : (tick ? 0 : m_c + 1);
         end
      end
   endtask

   // Scoreboard side: compare against the model away from the edge, log transfers.
   task automatic monitor_loop();
      forever begin
         @(negedge clk);
         chk("sb_val", 32'(o_data_val), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) chk("sb_head", 32'(o_data), 32'(exp_q[0]));
         chk("sb_sent", 32'(o_sent_count), 32'(m_sent));
         chk("sb_drop", 32'(o_drop_count), 32'(m_drop));
         if (o_data_val && i_en) log_q.push_back(o_data);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int j;
      int base;
      int wraps;
      fork
         model_loop();
         monitor_loop();
      join_none

      // Reset held three cycles with generation and network enable high
      repeat (3) begin
         step();
         chk("rst_val", 32'(o_data_val), 32'd0);
         chk("rst_data", 32'(o_data), 32'd0);
         chk("rst_sent", 32'(o_sent_count), 32'd0);
         chk("rst_drop", 32'(o_drop_count), 32'd0);
      end
      reset = 1'b0;

      // Steady flow: valid exactly in cycles PERIOD, 2*PERIOD, 3*PERIOD
      for (int k = 1; k <= 13; k++) begin
         step();
         chk("flow_val", 32'(o_data_val), 32'((k % PERIOD) == 0));
      end
      chk("flow_sent", 32'(o_sent_count), 32'd3);
      chk("flow_npkt", 32'(log_q.size()), 32'd3);
      for (int k = 0; k < 3 && k < log_q.size(); k++) begin
         chk("flow_seq", 32'(log_q[k].seq), 32'(k));
         chk("flow_src", 32'(log_q[k].source), 32'(NID));
`ifndef NODE_TRAFFIC_RANDOM_EN
         chk("flow_dest", 32'(log_q[k].dest), 32'd4);
`endif
      end

      // Backpressure: six ticks into a four-deep FIFO
      reset = 1'b1; i_gen_en = 1'b0; i_en = 1'b0;
      step();
      reset = 1'b0; i_gen_en = 1'b1;
      repeat (6 * PERIOD) step();
      i_gen_en = 1'b0;
      chk("bp_drop", 32'(o_drop_count), 32'd2);
      chk("bp_val", 32'(o_data_val), 32'd1);
      chk("bp_head", 32'(o_data.seq), 32'd0);
      i_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("bp_drain_val", 32'(o_data_val), 32'd1);
         chk("bp_drain_seq", 32'(o_data.seq), 32'(k));
         step();
      end
      chk("bp_empty", 32'(o_data_val), 32'd0);
      i_gen_en = 1'b1;
      j = 0;
      while (!o_data_val && j < 3 * PERIOD) begin
         step();
         j++;
      end
      chk("bp_next_val", 32'(o_data_val), 32'd1);
      chk("bp_next_seq", 32'(o_data.seq), 32'd4);
      i_gen_en = 1'b0;
      step();

      // Full FIFO with a pop in the tick cycle
      reset = 1'b1; i_en = 1'b0;
      step();
      reset = 1'b0; i_gen_en = 1'b1;
      repeat (4 * PERIOD + 3) step();
      chk("fp_head", 32'(o_data.seq), 32'd0);
      i_en = 1'b1;
      step();
      i_en = 1'b0; i_gen_en = 1'b0;
      chk("fp_drop", 32'(o_drop_count), 32'd0);
      chk("fp_sent", 32'(o_sent_count), 32'd1);
      i_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("fp_occ_val", 32'(o_data_val), 32'd1);
         chk("fp_occ_seq", 32'(o_data.seq), 32'(k + 1));
         step();
      end
      chk("fp_occ_end", 32'(o_data_val), 32'd0);
      i_en = 1'b0;

      // Reset in the middle of operation with three buffered packets
      i_gen_en = 1'b1;
      repeat (3 * PERIOD) step();
      chk("mr_pre_val", 32'(o_data_val), 32'd1);
      chk("mr_pre_sent", 32'(o_sent_count), 32'd5);
      reset = 1'b1;
      step();
      reset = 1'b0; i_en = 1'b1;
      chk("mr_val", 32'(o_data_val), 32'd0);
      chk("mr_sent", 32'(o_sent_count), 32'd0);
      chk("mr_drop", 32'(o_drop_count), 32'd0);
      j = 0;
      while (!o_data_val && j < 3 * PERIOD) begin
         step();
         j++;
      end
      chk("mr_first_cycle", 32'(j), 32'(PERIOD));
      chk("mr_first_seq", 32'(o_data.seq), 32'd0);

`ifdef NODE_TRAFFIC_RANDOM_EN
      // Random destinations over 1000 packets, including three seq wraps
      reset = 1'b1;
      step();
      reset = 1'b0;
      base = log_q.size();
      j = 0;
      while ((log_q.size() - base) < 1000 && j < 1000 * PERIOD + 50) begin
         step();
         j++;
      end
      i_gen_en = 1'b0;
      chk("rnd_count", 32'(log_q.size() - base), 32'd1000);
      wraps = 0;
      for (int k = base; k < log_q.size(); k++) begin
         chk("rnd_not_self", 32'(log_q[k].dest == 4'(NID)), 32'd0);
         if (k > base && log_q[k-1].seq == 8'd255 && log_q[k].seq == 8'd0) wraps++;
      end
      chk("rnd_seq_wraps", 32'(wraps), 32'd3);
`else
      base = 0;
      wraps = 0;
`endif

      i_gen_en = 1'b0; i_en = 1'b1;
      repeat (2 * PERIOD) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
